// File: rtl/signal_replicator.sv
// signal_replicator: registered fan-out of one N-bit word onto M lanes.
// Optional macro SIGNAL_REPLICATOR_INVERT_EN adds per-lane inversion.
//
// Parameters:
//   WIRE      log2 of lane width, N = 2**WIRE bits
//   WAY       log2 of lane count, M = 2**WAY lanes
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset, clears out and out_valid
//   in        word to replicate (N bits)
//   in_valid  load strobe, in is sampled when high
//   way_en    per-lane load enable (M bits), bit i gates lane i
//   inv_mask  (SIGNAL_REPLICATOR_INVERT_EN only) lane i loads ~in when set
//   out       concatenated lanes, lane i at [i*N +: N], lane 0 at LSBs
//   out_valid registered copy of in_valid
module signal_replicator #(
    parameter int WIRE = 3,
    parameter int WAY  = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [(1<<WIRE)-1:0]                in,
    input  logic                                in_valid,
    input  logic [(1<<WAY)-1:0]                 way_en,
`ifdef SIGNAL_REPLICATOR_INVERT_EN
    input  logic [(1<<WAY)-1:0]                 inv_mask,
`endif
    output logic [(1<<WAY)*(1<<WIRE)-1:0]       out,
    output logic                                out_valid
);

    localparam int N = 1 << WIRE;
    localparam int M = 1 << WAY;

    logic [M*N-1:0] out_q;
    logic [M*N-1:0] out_d;
    logic           valid_q;
    logic           valid_d;
    logic [M-1:0]   flip;

`ifdef SIGNAL_REPLICATOR_INVERT_EN
    assign flip = inv_mask;
`else
    assign flip = '0;
`endif

    // Disabled lanes, or every lane without a strobe, keep their value.
    always_comb begin
        out_d   = out_q;
        valid_d = in_valid;
        for (int i = 0; i < M; i++) begin
            if (in_valid && way_en[i]) begin
                out_d[i*N +: N] = in ^ {N{flip[i]}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_signal_replicator.sv
// tb_signal_replicator: directed checks of signal_replicator at
// WIRE=3, WAY=2 (four 8-bit lanes, 32-bit output bus).
module tb_signal_replicator;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in;
    logic        in_valid;
    logic [3:0]  way_en;
`ifdef SIGNAL_REPLICATOR_INVERT_EN
    logic [3:0]  inv_mask;
`endif
    logic [31:0] out;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    signal_replicator #(
        .WIRE(3),
        .WAY (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .in_valid (in_valid),
        .way_en   (way_en),
`ifdef SIGNAL_REPLICATOR_INVERT_EN
        .inv_mask (inv_mask),
`endif
        .out      (out),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        in       = 8'h00;
        in_valid = 1'b0;
        way_en   = 4'h0;
`ifdef SIGNAL_REPLICATOR_INVERT_EN
        inv_mask = 4'h0;
`endif

        // Async reset mid-cycle, before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out", out, 32'h0000_0000);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);

        // Held in reset through a load edge
        in       = 8'hFF;
        in_valid = 1'b1;
        way_en   = 4'hF;
        @(posedge clk); #1;
        chk("rst_hold_out", out, 32'h0000_0000);
        chk("rst_hold_valid", {31'b0, out_valid}, 32'd0);

        // Release and full broadcast
        @(negedge clk);
        rst_n    = 1'b1;
        in       = 8'hBB;
        in_valid = 1'b1;
        way_en   = 4'b1111;
        @(posedge clk); #1;
        chk("bcast_out", out, 32'hBBBB_BBBB);
        chk("bcast_lane0", {24'b0, out[7:0]}, 32'd187);
        chk("bcast_lane1", {24'b0, out[15:8]}, 32'd187);
        chk("bcast_valid", {31'b0, out_valid}, 32'd1);

        // Back-to-back reload
        @(negedge clk);
        in = 8'hCB;
        @(posedge clk); #1;
        chk("reload_out", out, 32'hCBCB_CBCB);
        chk("reload_lane3", {24'b0, out[31:24]}, 32'd203);
        chk("reload_valid", {31'b0, out_valid}, 32'd1);

        // No strobe: hold, valid drops
        @(negedge clk);
        in       = 8'h11;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("nostrobe_out", out, 32'hCBCB_CBCB);
        chk("nostrobe_valid", {31'b0, out_valid}, 32'd0);

        // Restore 0xBB everywhere, then partial enable
        @(negedge clk);
        in       = 8'hBB;
        in_valid = 1'b1;
        way_en   = 4'b1111;
        @(posedge clk); #1;
        chk("restore_out", out, 32'hBBBB_BBBB);
        @(negedge clk);
        in     = 8'hCB;
        way_en = 4'b0101;
        @(posedge clk); #1;
        chk("partial_out", out, 32'hBBCB_BBCB);
        chk("partial_valid", {31'b0, out_valid}, 32'd1);

        // Strobe with no lanes enabled
        @(negedge clk);
        in     = 8'h55;
        way_en = 4'b0000;
        @(posedge clk); #1;
        chk("noway_out", out, 32'hBBCB_BBCB);
        chk("noway_valid", {31'b0, out_valid}, 32'd1);

        // Single upper lane
        @(negedge clk);
        in     = 8'h3C;
        way_en = 4'b1000;
        @(posedge clk); #1;
        chk("lane3_out", out, 32'h3CCB_BBCB);

        // Enables set but no strobe
        @(negedge clk);
        in       = 8'h11;
        in_valid = 1'b0;
        way_en   = 4'b1111;
        @(posedge clk); #1;
        chk("hold_out", out, 32'h3CCB_BBCB);
        chk("hold_valid", {31'b0, out_valid}, 32'd0);

        // Reset asserted on a load edge
        @(negedge clk);
        in       = 8'h77;
        in_valid = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstload_out", out, 32'h0000_0000);
        chk("rstload_valid", {31'b0, out_valid}, 32'd0);

        // Release with a load on the very first edge
        @(negedge clk);
        rst_n    = 1'b1;
        in       = 8'hA5;
        in_valid = 1'b1;
        way_en   = 4'b0011;
        @(posedge clk); #1;
        chk("postrst_out", out, 32'h0000_A5A5);
        chk("postrst_valid", {31'b0, out_valid}, 32'd1);

`ifdef SIGNAL_REPLICATOR_INVERT_EN
        // Inversion on lane 1 only
        @(negedge clk);
        in       = 8'hBB;
        way_en   = 4'b1111;
        inv_mask = 4'b0010;
        @(posedge clk); #1;
        chk("inv_out", out, 32'hBBBB_44BB);
`endif

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("end_valid", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
